// File: rtl/wb_arbiter.sv
// Write-back arbiter: two producers (ALU, load) share the register file's single
// write port through one-entry holding buffers and a registered output stage.

module wb_arb_buf #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          grant,
    input  logic          other_hold,
    input  logic          other_load,
    output logic          ready,
    output logic          load,
    output logic          full,
    output logic          age,
    output logic [AW-1:0] baddr,
    output logic [DW-1:0] bdata
);
    // age=1 marks the younger entry; only meaningful while both buffers are full
    assign ready = !full || grant;
    assign load  = valid && ready && (addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            age   <= 1'b0;
            baddr <= '0;
            bdata <= '0;
        end else if (load) begin
            full  <= 1'b1;
            age   <= other_hold;
            baddr <= addr;
            bdata <= data;
        end else begin
            if (grant)
                full <= 1'b0;
            if (other_load)
                age <= 1'b0;
        end
    end
endmodule

module wb_arbiter #(
    parameter int RegAddrWidth = 5,
    parameter int DataWidth    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [RegAddrWidth-1:0]      alu_waddr,
    input  logic [DataWidth-1:0]         alu_wdata,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [RegAddrWidth-1:0]      mem_waddr,
    input  logic [DataWidth-1:0]         mem_wdata,
    output logic                         we,
    output logic [RegAddrWidth-1:0]      waddr,
    output logic [DataWidth-1:0]         wdata,
    output logic [(1<<RegAddrWidth)-1:0] pend_mask,
    output logic                         idle
);
    localparam int NumSrc = 2;  // 0 = ALU, 1 = mem

    logic [NumSrc-1:0]                   src_valid, src_ready, src_load;
    logic [NumSrc-1:0]                   full, age, gnt, hold;
    logic [NumSrc-1:0][RegAddrWidth-1:0] src_addr, baddr;
    logic [NumSrc-1:0][DataWidth-1:0]    src_data, bdata;
    logic                                rr, tie;

    assign src_valid = {mem_valid, alu_valid};
    assign src_addr  = {mem_waddr, alu_waddr};
    assign src_data  = {mem_wdata, alu_wdata};
    assign alu_ready = src_ready[0];
    assign mem_ready = src_ready[1];
    assign hold      = full & ~gnt;

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        wb_arb_buf #(.AW(RegAddrWidth), .DW(DataWidth)) u_buf (
            .clk        (clk),
            .rst        (rst),
            .valid      (src_valid[i]),
            .addr       (src_addr[i]),
            .data       (src_data[i]),
            .grant      (gnt[i]),
            .other_hold (hold[NumSrc-1-i]),
            .other_load (src_load[NumSrc-1-i]),
            .ready      (src_ready[i]),
            .load       (src_load[i]),
            .full       (full[i]),
            .age        (age[i]),
            .baddr      (baddr[i]),
            .bdata      (bdata[i])
        );
    end

    // Grant depends only on registered buffer state, never on the request inputs
    always_comb begin
        gnt = '0;
        tie = 1'b0;
        case (full)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (age[0] != age[1]) begin
                    gnt = age[0] ? 2'b10 : 2'b01;
                end else begin
                    tie = 1'b1;
                    gnt = rr ? 2'b10 : 2'b01;
                end
            end
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr    <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            if (tie)
                rr <= gnt[0];  // point at the loser
            if (gnt[0]) begin
                we    <= 1'b1;
                waddr <= baddr[0];
                wdata <= bdata[0];
            end else if (gnt[1]) begin
                we    <= 1'b1;
                waddr <= baddr[1];
                wdata <= bdata[1];
            end else begin
                we <= 1'b0;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NumSrc; i++)
            if (full[i])
                pend_mask[baddr[i]] = 1'b1;
    end

    assign idle = (full == '0) && !we;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the register file's single write port. Two producers compete for that port: the ALU result path and the load (memory) result path. Each producer gets a one-entry holding buffer and a valid/ready handshake, and the block issues at most one registered write per cycle to the regfile's we/waddr/wdata inputs. It also exports a pending-write mask that decode uses for stall decisions.

## Interface
- RegAddrWidth, default 5: register address width; register count is 2^RegAddrWidth.
- DataWidth, default 32: write data width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted at this edge when valid&&ready.
- alu_waddr  in  RegAddrWidth  ALU destination register.
- alu_wdata  in  DataWidth  ALU result.
- mem_valid  in  1  load write-back request.
- mem_ready  out  1  load request accepted at this edge when valid&&ready.
- mem_waddr  in  RegAddrWidth  load destination register.
- mem_wdata  in  DataWidth  load data.
- we  out  1  regfile write enable (registered).
- waddr  out  RegAddrWidth  regfile write address (registered).
- wdata  out  DataWidth  regfile write data (registered).
- pend_mask  out  2^RegAddrWidth  bit i = 1 while a buffered write to register i is waiting.
- idle  out  1  both buffers empty and we=0.

## Operation
- Per source state: buffer {full, waddr, wdata, age}. Shared state: round-robin pointer rr, where 0 means ALU is preferred.
- Grant is computed combinationally from registered state only.
  - If exactly one buffer is full, that buffer is granted.
  - If both are full and their ages differ, the older buffer is granted.
  - If both are full and their ages are equal (loaded at the same edge), the source selected by rr is granted.
  - If neither is full, there is no grant.
- At each edge, a granted buffer drains into the output register: we<=1, waddr/wdata <= buffer contents. With no grant, we<=0 and waddr/wdata hold their values.
- rr flips only on a tie-broken grant, and then points to the loser.
- Ready: x_ready = !x_full || x_granted. There is no combinational path from any valid or data input to any ready output.
- Accept rule: an accepted request with waddr != 0 loads the buffer (full<=1) and stamps its age.
- x0 rule: an accepted request with waddr == 0 is consumed and discarded. The buffer is not loaded and no write is ever issued for it.
- Age is a single relative bit. When one buffer loads while the other stays full, the new entry is younger. This guarantees writes to the same register leave the block in acceptance order.
- pend_mask is the OR of one-hot(alu buffer waddr) if full and one-hot(mem buffer waddr) if full. It does not include the output stage; the regfile's same-cycle write-to-read forwarding covers that stage.
- Reset (asynchronous, at any time):
  - Buffers are cleared and buffered writes are lost.
  - rr=0, we=0, waddr=0, wdata=0, pend_mask=0.
  - idle=1, alu_ready=1, mem_ready=1.

## Timing
- Latency: request accepted at edge E0 → buffer full in cycle E0+1 → granted → we=1 in cycle E0+2 → regfile written at edge E0+3 (readers see it via forwarding in cycle E0+2).
- Throughput:
  - The block issues one write per cycle in aggregate.
  - A single active source sustains one accepted request per cycle.
  - With both sources streaming, each source sustains one request every 2 cycles.
- Simultaneous accept of both sources on an empty block: ALU issues first (rr=0), mem issues the next cycle, then rr=1.
- A buffer granted and refilled at the same edge stays full. The new entry's age is younger than the other buffer's entry if that buffer is full.
- Outputs hold through a back-to-back drain of the same address. we stays 1 for consecutive grants.
- Reset deassertion: the first accept is possible at the first rising edge after rst falls.

## Test plan
- Reset: assert rst mid-stream with both buffers full → we=0, pend_mask=0, idle=1, both ready=1 immediately, with no clock edge required.
- Single source: ALU issues waddr=5, data=0x11 at E0 → we=1, waddr=5, wdata=0x11 in cycle E0+2; pend_mask[5]=1 only during cycle E0+1.
- Tie: ALU(3,0xA) and mem(4,0xB) accepted at the same edge → writes reg3 then reg4 on consecutive cycles. Repeat the tie → reg4-source (mem) goes first.
- Ordering: mem(7,0x1) accepted at E0 while the ALU buffer is busy, then ALU(7,0x2) accepted at E1 → write 0x1 precedes 0x2, so reg7 ends at 0x2.
- x0 drop: ALU(0,0xDEAD) accepted → ready stays 1, we never asserts, pend_mask stays 0, idle=1 one cycle later.
- Streaming: both valid held high for 10 cycles with distinct addresses → 10 writes in 10 consecutive cycles, alternating sources, and each ready is high every other cycle.
